// File: rtl/bnn_result_presenter.sv
// Output stage after the final BNN layer: holds the digit class for an off-chip reader,
// handshakes on a synchronised ack pin, and reports overrun and out-of-range class codes.
module bnn_result_presenter #(
   parameter int unsigned ANS_W       = 4,
   parameter int unsigned CLASSES     = 10,
   parameter int unsigned CNT_W       = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [2:0]  LOAD_STATE  = 3'd1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       state,
   input  logic [ANS_W-1:0] answer_in,
   input  logic             layer_3_done,
   input  logic             ack_in,
   output logic [ANS_W-1:0] answer_out,
   output logic             result_valid,
   output logic             overrun,
   output logic             class_err,
   output logic [CNT_W-1:0] infer_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2
   } fsm_t;

   fsm_t                   fsm;
   logic                   done_prev;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_d1;
   logic                   ack_s;
   logic                   ack_rise;
   logic                   done_rise;
   logic                   bad_class;
   logic                   overrun_set;
   logic                   class_err_set;

   // Edge detection and flag-set conditions for the current cycle.
   always_comb begin
      ack_s         = ack_sync[SYNC_STAGES-1];
      ack_rise      = ack_s & ~ack_d1;
      done_rise     = layer_3_done & ~done_prev;
      bad_class     = (32'(answer_in) >= CLASSES);
      overrun_set   = 1'b0;
      class_err_set = 1'b0;
      if (done_rise && (fsm != ST_IDLE)) begin
         overrun_set = 1'b1;
      end else begin
         overrun_set = 1'b0;
      end
      if (done_rise && (fsm == ST_IDLE) && bad_class) begin
         class_err_set = 1'b1;
      end else begin
         class_err_set = 1'b0;
      end
   end

   // Handshake FSM, ack synchroniser and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm          <= ST_IDLE;
         done_prev    <= 1'b0;
         ack_sync     <= '0;
         ack_d1       <= 1'b0;
         answer_out   <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
         class_err    <= 1'b0;
         infer_count  <= '0;
      end else begin
         done_prev <= layer_3_done;
         ack_sync  <= {ack_sync[SYNC_STAGES-2:0], ack_in};
         ack_d1    <= ack_s;

         case (fsm)
            ST_IDLE: begin
               if (done_rise) begin
                  answer_out   <= bad_class ? {ANS_W{1'b1}} : answer_in;
                  infer_count  <= infer_count + CNT_W'(1'b1);
                  result_valid <= 1'b1;
                  fsm          <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // An ack in the same cycle as a new done wins; the new result is dropped.
               if (ack_rise) begin
                  result_valid <= 1'b0;
                  fsm          <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (!ack_s) begin
                  fsm <= ST_IDLE;
               end
            end
            default: begin
               result_valid <= 1'b0;
               fsm          <= ST_IDLE;
            end
         endcase

         // Load phase clears the sticky flags and beats any simultaneous set.
         if (state == LOAD_STATE) begin
            overrun   <= 1'b0;
            class_err <= 1'b0;
         end else begin
            if (overrun_set) begin
               overrun <= 1'b1;
            end
            if (class_err_set) begin
               class_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bnn_result_presenter.sv
// Directed bench for bnn_result_presenter: reader-ownership model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_bnn_result_presenter;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] state;
   logic [3:0] answer_in;
   logic       layer_3_done;
   logic       ack_in;
   logic [3:0] answer_out;
   logic       result_valid;
   logic       overrun;
   logic       class_err;
   logic [1:0] infer_count;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   bnn_result_presenter dut (
      .clk(clk), .rst_n(rst_n), .state(state), .answer_in(answer_in),
      .layer_3_done(layer_3_done), .ack_in(ack_in), .answer_out(answer_out),
      .result_valid(result_valid), .overrun(overrun), .class_err(class_err),
      .infer_count(infer_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: who owns the result (free / reader holding it / reader dropping ack).
   int  owner;
   int  m_ans, m_cnt;
   bit  m_valid, m_ovr, m_err, d_prev;
   bit  hist [0:S];

   always @(posedge clk) begin : model
      bit rise, alevel, aedge, ovr, err;
      if (!rst_n) begin
         owner = 0; m_ans = 0; m_cnt = 0; m_valid = 0; m_ovr = 0; m_err = 0; d_prev = 0;
         for (int i = 0; i <= S; i++) hist[i] = 0;
      end else begin
         rise   = layer_3_done && !d_prev;
         alevel = hist[S-1];
         aedge  = alevel && !hist[S];
         ovr = 0; err = 0;
         if (owner == 0) begin
            if (rise) begin
               if (answer_in >= 10) begin m_ans = 15; err = 1; end
               else m_ans = answer_in;
               m_cnt   = (m_cnt + 1) % 4;
               m_valid = 1;
               owner   = 1;
            end
         end else if (owner == 1) begin
            if (rise) ovr = 1;
            if (aedge) begin m_valid = 0; owner = 2; end
         end else begin
            if (rise) ovr = 1;
            if (!alevel) owner = 0;
         end
         if (state == 3'd1) begin m_ovr = 0; m_err = 0; end
         else begin m_ovr = m_ovr | ovr; m_err = m_err | err; end
         d_prev = layer_3_done;
         for (int i = S; i >= 1; i--) hist[i] = hist[i-1];
         hist[0] = ack_in;
      end
   end

   // Compare DUT against the model on the falling edge of every enabled cycle.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_answer_out", answer_out, m_ans);
         chk("m_result_valid", result_valid, m_valid);
         chk("m_overrun", overrun, m_ovr);
         chk("m_class_err", class_err, m_err);
         chk("m_infer_count", infer_count, m_cnt);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   int seq5 [5] = '{1, 2, 3, 0, 1};

   initial begin
      rst_n = 1'b0; state = 3'd0; answer_in = 4'd0; layer_3_done = 1'b0; ack_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cmp_en = 1'b1;
      chk("reset_answer", answer_out, 0);
      chk("reset_valid", result_valid, 0);
      chk("reset_count", infer_count, 0);

      // 1: long done level captures exactly once
      rst_n = 1'b1; answer_in = 4'd7; layer_3_done = 1'b1;
      cyc(1);
      chk("t1_answer", answer_out, 7);
      chk("t1_valid", result_valid, 1);
      chk("t1_count", infer_count, 1);
      cyc(4);
      layer_3_done = 1'b0;
      chk("t1_single_capture", infer_count, 1);

      // 2: ack latency, then done during release is dropped
      ack_in = 1'b1;
      cyc(2);
      chk("t2_valid_before", result_valid, 1);
      cyc(1);
      chk("t2_valid_fall", result_valid, 0);
      answer_in = 4'd3; layer_3_done = 1'b1;
      cyc(1);
      chk("t2_overrun", overrun, 1);
      chk("t2_answer_kept", answer_out, 7);
      layer_3_done = 1'b0; ack_in = 1'b0;
      cyc(4);

      // 3: illegal class, then load-state clear
      answer_in = 4'd12; layer_3_done = 1'b1;
      cyc(1);
      chk("t3_answer_f", answer_out, 15);
      chk("t3_class_err", class_err, 1);
      chk("t3_count", infer_count, 2);
      layer_3_done = 1'b0; state = 3'd1;
      cyc(1);
      chk("t3_err_clr", class_err, 0);
      chk("t3_ovr_clr", overrun, 0);
      state = 3'd0;

      // 4: done rise coincides with ack rise in HOLD
      ack_in = 1'b1;
      cyc(2);
      layer_3_done = 1'b1; answer_in = 4'd2;
      cyc(1);
      chk("t4_valid", result_valid, 0);
      chk("t4_overrun", overrun, 1);
      chk("t4_answer", answer_out, 15);
      layer_3_done = 1'b0; ack_in = 1'b0;
      cyc(4);
      state = 3'd1;
      cyc(1);
      state = 3'd0;

      // 5: counter wrap over five handshakes
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         answer_in = 4'(i); layer_3_done = 1'b1;
         cyc(1);
         chk("t5_count", infer_count, seq5[i]);
         chk("t5_answer", answer_out, i);
         layer_3_done = 1'b0; ack_in = 1'b1;
         cyc(4);
         ack_in = 1'b0;
         cyc(4);
      end

      // 6: reset while holding, done already high at release
      answer_in = 4'd5; layer_3_done = 1'b1;
      cyc(1);
      chk("t6_valid_hold", result_valid, 1);
      rst_n = 1'b0;
      cyc(1);
      chk("t6_rst_answer", answer_out, 0);
      chk("t6_rst_valid", result_valid, 0);
      chk("t6_rst_count", infer_count, 0);
      rst_n = 1'b1; answer_in = 4'd9;
      cyc(1);
      chk("t6_answer", answer_out, 9);
      chk("t6_valid", result_valid, 1);
      chk("t6_count", infer_count, 1);
      chk("t6_class_ok", class_err, 0);
      layer_3_done = 1'b0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
